sync_fifo_lvl: RTL and testbench
================================

SYNC_FIFO_LVL -- requirements
Module: sync_fifo_lvl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of entries; a power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default 8: data bits per entry.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost-full threshold, in the range 1..DEPTH-1.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost-empty threshold, in the range 1..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port i_clk, input, 1 bit: clock, rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port i_clr, input, 1 bit: synchronous flush.
REQ-009 SHALL have port i_wr_en, input, 1 bit: write request.
REQ-010 SHALL have port i_data_in, input, WIDTH bits: write data.
REQ-011 SHALL have port i_rd_en, input, 1 bit: read request in standard mode, pop request in FWFT mode.
REQ-012 SHALL have port o_data_out, output, WIDTH bits: read data.
REQ-013 SHALL have port o_valid, output, 1 bit: o_data_out is meaningful.
REQ-014 SHALL have ports o_full, o_empty, o_afull and o_aempty, each output, 1 bit: status flags.
REQ-015 SHALL have port o_level, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-016 SHALL have ports o_ovf and o_udf, each output, 1 bit: sticky error flags (present only under the macro in REQ-036).

Function
REQ-017 SHALL accept a write when i_wr_en is high and o_full is low; a write request while full SHALL be dropped and leave all state unchanged.
REQ-018 SHALL accept a read when i_rd_en is high and o_empty is low; a read request while empty SHALL leave all state unchanged.
REQ-019 SHALL use (ADDR+1)-bit read and write pointers, where ADDR = $clog2(DEPTH), and wrap at DEPTH with the extra bit toggling.
REQ-020 SHALL assert o_empty when the two pointers are equal.
REQ-021 SHALL assert o_full when the pointer MSBs differ and the lower ADDR bits are equal.
REQ-022 SHALL compute o_level as wr_ptr - rd_ptr, modulo 2^(ADDR+1), giving a range of 0..DEPTH.
REQ-023 SHALL assert o_afull when o_level >= AF_THRESH.
REQ-024 SHALL assert o_aempty when o_level <= AE_THRESH.
REQ-025 SHALL derive all status flags combinationally from the registered pointers, so each flag updates one cycle after the accepted operation.
REQ-026 SHALL, when a read and a write are accepted in the same cycle, advance both pointers and leave o_level unchanged.
REQ-027 SHALL, when full, accept a simultaneous read and drop the write (no pass-through).
REQ-028 SHALL, when empty, accept a simultaneous write and ignore the read (no bypass).
REQ-029 SHALL, in standard mode (FWFT=0), register o_data_out from mem[rd_ptr] on an accepted read, so data is visible the following cycle.
REQ-030 SHALL, in standard mode, pulse o_valid high for exactly that following cycle, and hold o_data_out otherwise.
REQ-031 SHALL, in FWFT mode (FWFT=1), drive o_data_out as mem[rd_ptr] combinationally and drive o_valid as ~o_empty.
REQ-032 SHALL, in FWFT mode, present the new head on the cycle after an accepted pop.
REQ-033 SHALL, when i_clr is high, zero both pointers and clear o_valid at the next edge, overriding any simultaneous read or write; memory contents are not cleared.

Reset
REQ-034 SHALL, while i_rst_n is low, asynchronously force pointers = 0, o_data_out = 0, o_valid = 0, o_ovf = 0 and o_udf = 0.
REQ-035 SHALL therefore present after reset: o_empty = 1, o_aempty = 1, o_full = 0, o_afull = 0, o_level = 0; an operation in flight at reset assertion SHALL be discarded.

Configuration
REQ-036 SHALL, with SYNC_FIFO_LVL_ERR_EN defined, set o_ovf on a dropped write and o_udf on an ignored read; both flags SHALL stay set until i_clr or reset.
REQ-037 SHALL, without SYNC_FIFO_LVL_ERR_EN defined, tie o_ovf and o_udf to 0 and include no error-flag registers.

Structure
REQ-038 SHALL take from package sync_fifo_pkg the default DEPTH/WIDTH constants and a function computing the level width.
REQ-039 SHALL place storage in one sub-module, fifo_ram_2p: one write port, a combinational read port and no reset on the array; the output register and FWFT selection SHALL stay in sync_fifo_lvl.

Verification
REQ-040 SHALL cover standard-mode ordering: with DEPTH=16, write 0x01..0x10, then read 16 times -> o_data_out = 0x01..0x10, each one cycle after its read request; o_full = 1 after the 16th write; o_empty = 1 after the 16th read.
REQ-041 SHALL cover overflow: when full, write 0xAA -> dropped, o_level stays 16, o_ovf = 1 (macro defined) or 0 (macro undefined); the next read returns the oldest entry, not 0xAA.
REQ-042 SHALL cover simultaneous operations: at level 5, rd+wr for 20 cycles -> o_level holds 5 and data stays in order across pointer wrap; when full, rd+wr -> level becomes 15.
REQ-043 SHALL cover FWFT mode: write 0x5A into an empty FIFO -> the next cycle o_valid = 1 and o_data_out = 0x5A with no read; a pop then drives o_valid to 0.
REQ-044 SHALL cover thresholds: with AF_THRESH=14 and AE_THRESH=2, fill one entry at a time -> o_aempty deasserts at level 3 and o_afull asserts at level 14.
REQ-045 SHALL cover clear and reset: i_clr at level 9 together with a write -> level 0, o_empty = 1, write discarded; asserting i_rst_n low mid-burst -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous level-reporting FIFO.
package sync_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    // One extra bit so a completely full FIFO (level == depth) can be represented.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port storage array: one synchronous write port, one combinational read port.
module fifo_ram_2p
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; entries are only ever read after being written,
    // and leaving it unreset lets it map onto RAM primitives.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with occupancy level, almost-full/empty flags and optional FWFT read mode.
// Define SYNC_FIFO_LVL_ERR_EN to build the sticky overflow/underflow flags o_ovf/o_udf.
module sync_fifo_lvl
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clr,
    input  logic                        i_wr_en,
    input  logic [WIDTH-1:0]            i_data_in,
    input  logic                        i_rd_en,
    output logic [WIDTH-1:0]            o_data_out,
    output logic                        o_valid,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_afull,
    output logic                        o_aempty,
    output logic [lvl_width(DEPTH)-1:0] o_level,
    output logic                        o_ovf,
    output logic                        o_udf
);

    localparam int ADDR  = $clog2(DEPTH);
    localparam int LVL_W = lvl_width(DEPTH);
    localparam logic [LVL_W-1:0] AF_LVL = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] AE_LVL = LVL_W'(AE_THRESH);
    localparam logic [ADDR:0]    PTR_ONE = (ADDR + 1)'(1);

    logic [ADDR:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             wr_acc, rd_acc;

    assign wr_acc = i_wr_en && !o_full;
    assign rd_acc = i_rd_en && !o_empty;

    assign o_empty  = (wr_ptr == rd_ptr);
    assign o_full   = (wr_ptr[ADDR] != rd_ptr[ADDR]) &&
                      (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]);
    assign o_level  = wr_ptr - rd_ptr;
    assign o_afull  = (o_level >= AF_LVL);
    assign o_aempty = (o_level <= AE_LVL);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    fifo_ram_2p #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_acc && !i_clr),
        .i_waddr (wr_ptr[ADDR-1:0]),
        .i_wdata (i_data_in),
        .i_raddr (rd_ptr[ADDR-1:0]),
        .o_rdata (rd_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Masked while empty so the port reads zero out of reset and after a flush.
            assign o_data_out = o_empty ? '0 : rd_data;
            assign o_valid    = !o_empty;
        end else begin : g_std
            logic [WIDTH-1:0] data_q;
            logic             valid_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (i_clr) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) data_q <= rd_data;
                end
            end

            assign o_data_out = data_q;
            assign o_valid    = valid_q;
        end
    endgenerate

`ifdef SYNC_FIFO_LVL_ERR_EN
    logic ovf_q, udf_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (i_clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (i_wr_en && o_full)  ovf_q <= 1'b1;
            if (i_rd_en && o_empty) udf_q <= 1'b1;
        end
    end

    assign o_ovf = ovf_q;
    assign o_udf = udf_q;
`else
    assign o_ovf = 1'b0;
    assign o_udf = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl: one standard-mode and one FWFT instance on shared stimulus.
module tb_sync_fifo_lvl;

`ifdef SYNC_FIFO_LVL_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n, i_clr, i_wr_en, i_rd_en;
    logic [7:0] i_data_in;

    logic [7:0] s_data_out, f_data_out;
    logic       s_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic       f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [4:0] s_level, f_level;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    sync_fifo_lvl #(
        .DEPTH(16), .WIDTH(8), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)
    ) u_std (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr),
        .i_wr_en(i_wr_en), .i_data_in(i_data_in), .i_rd_en(i_rd_en),
        .o_data_out(s_data_out), .o_valid(s_valid),
        .o_full(s_full), .o_empty(s_empty), .o_afull(s_afull), .o_aempty(s_aempty),
        .o_level(s_level), .o_ovf(s_ovf), .o_udf(s_udf)
    );

    sync_fifo_lvl #(
        .DEPTH(16), .WIDTH(8), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)
    ) u_fwft (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr),
        .i_wr_en(i_wr_en), .i_data_in(i_data_in), .i_rd_en(i_rd_en),
        .o_data_out(f_data_out), .o_valid(f_valid),
        .o_full(f_full), .o_empty(f_empty), .o_afull(f_afull), .o_aempty(f_aempty),
        .o_level(f_level), .o_ovf(f_ovf), .o_udf(f_udf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Standard-instance status flags expected for a given occupancy (AF=14, AE=2, DEPTH=16).
    task automatic status(input string tag, input int lvl);
        check({tag, "_level"},  s_level,  lvl);
        check({tag, "_empty"},  s_empty,  lvl == 0);
        check({tag, "_full"},   s_full,   lvl == 16);
        check({tag, "_afull"},  s_afull,  lvl >= 14);
        check({tag, "_aempty"}, s_aempty, lvl <= 2);
    endtask

    task automatic cyc(input logic wr, input logic rd, input logic [7:0] d);
        i_wr_en   = wr;
        i_rd_en   = rd;
        i_data_in = d;
        @(posedge i_clk);
        #1;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_clr = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_data_in = '0;
        repeat (2) @(posedge i_clk);
        #1;
        status("rst", 0);
        check("rst_data", s_data_out, 0);
        check("rst_valid", s_valid, 0);
        check("rst_ovf", s_ovf, 0);
        check("rst_udf", s_udf, 0);
        check("rst_fvalid", f_valid, 0);
        check("rst_fdata", f_data_out, 0);
        i_rst_n = 1'b1;

        // Fill 0x01..0x10 one per cycle; thresholds cross at levels 3 and 14.
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b0, 8'(k));
            status("fill", k);
            check("fill_fhead", f_data_out, 8'h01);
            check("fill_fvalid", f_valid, 1);
        end
        check("fill_svalid", s_valid, 0);

        cyc(1'b1, 1'b0, 8'hAA);
        status("ovf", 16);
        check("ovf_flag", s_ovf, ERR);
        check("ovf_fflag", f_ovf, ERR);

        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("rd_data", s_data_out, k);
            check("rd_valid", s_valid, 1);
            status("rd", 16 - k);
            check("rd_fvalid", f_valid, k < 16);
            if (k < 16) check("rd_fhead", f_data_out, k + 1);
        end
        cyc(1'b0, 1'b0, 8'h00);
        check("idle_data", s_data_out, 8'h10);
        check("idle_valid", s_valid, 0);

        cyc(1'b0, 1'b1, 8'h00);
        status("udf", 0);
        check("udf_flag", s_udf, ERR);
        check("udf_valid", s_valid, 0);
        check("udf_data", s_data_out, 8'h10);

        // Level 5, then 20 simultaneous rd+wr cycles across the pointer wrap.
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 8'(8'h20 + k));
        status("sim_fill", 5);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b1, 8'(8'h25 + k));
            check("sim_data", s_data_out, 'h20 + k);
            status("sim", 5);
        end
        for (int k = 0; k < 11; k++) cyc(1'b1, 1'b0, 8'(8'h39 + k));
        status("sim_full", 16);
        cyc(1'b1, 1'b1, 8'hBB);
        status("full_rdwr", 15);
        check("full_rdwr_data", s_data_out, 8'h34);

        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("drain_data", s_data_out, 'h35 + k);
        end
        status("pre_clr", 9);

        i_clr = 1'b1;
        cyc(1'b1, 1'b0, 8'hCC);
        i_clr = 1'b0;
        status("clr", 0);
        check("clr_valid", s_valid, 0);
        check("clr_fvalid", f_valid, 0);
        check("clr_ovf", s_ovf, 0);
        check("clr_udf", s_udf, 0);

        // FWFT: head appears without a read; a pop empties it.
        cyc(1'b1, 1'b0, 8'h5A);
        check("fwft_valid", f_valid, 1);
        check("fwft_data", f_data_out, 8'h5A);
        check("fwft_svalid", s_valid, 0);
        cyc(1'b0, 1'b0, 8'h00);
        check("fwft_hold_valid", f_valid, 1);
        check("fwft_hold_data", f_data_out, 8'h5A);
        cyc(1'b0, 1'b1, 8'h00);
        check("fwft_pop_valid", f_valid, 0);
        check("fwft_pop_empty", f_empty, 1);
        check("fwft_std_valid", s_valid, 1);
        check("fwft_std_data", s_data_out, 8'h5A);

        // Reset asserted mid-burst with an operation pending.
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'(8'h61 + k));
        status("burst", 3);
        i_wr_en = 1'b1; i_rd_en = 1'b1; i_data_in = 8'h70;
        #2;
        i_rst_n = 1'b0;
        #1;
        status("midrst", 0);
        check("midrst_data", s_data_out, 0);
        check("midrst_valid", s_valid, 0);
        check("midrst_fvalid", f_valid, 0);
        check("midrst_fdata", f_data_out, 0);
        check("midrst_ovf", s_ovf, 0);
        check("midrst_udf", s_udf, 0);
        @(posedge i_clk);
        #1;
        i_wr_en = 1'b0; i_rd_en = 1'b0;
        status("inrst", 0);
        i_rst_n = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        status("postrst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
